event_framer: RTL and testbench

Parametrised trigger-event framer. It sits between the trigger logic and the SPI readout. On each trigger it captures the channel comparator word, the trigger ID and a free-running cycle timestamp, and packs them into a byte-framed record (0x7E … 0x7D). Records are buffered in a DEPTH-entry FIFO and streamed one byte at a time over a valid/ready interface. This replaces the fixed single-record 128-bit data register with a multi-event buffer whose widths are configurable.

---
 rtl/event_framer_if.sv | 25 ++
 rtl/event_framer.sv | 193 +++++++++++++++++++
 tb/tb_event_framer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_framer_if.sv
// -----------------------------------------------------------------------------
// event_framer_if
//   Byte stream from the event framer to the SPI readout.
//
//   Handshake: a byte transfers on every rising edge where out_valid and
//   out_ready are both high. Once out_valid is raised, out_data, out_last and
//   out_valid stay constant until that transfer happens. out_ready may be driven
//   freely, and the producer never waits for out_ready before raising
//   out_valid.
//
//   Signals:
//     out_data   producer -> consumer  current frame byte
//     out_valid  producer -> consumer  out_data holds a byte
//     out_last   producer -> consumer  high with the closing 0x7D byte
//     out_ready  consumer -> producer  consumer takes the byte this edge
// -----------------------------------------------------------------------------
interface event_framer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/event_framer.sv
// -----------------------------------------------------------------------------
// event_framer
//   Captures {trigger ID, cycle timestamp, comparator channels, drop count} on
//   each trigger pulse, buffers up to DEPTH records in a FIFO and streams each
//   one as a byte frame: 0x7E, ID, timestamp, channels, drop byte, 0x7D
//   (MSB first within every field).
//
//   Optional feature: define OPENTRIG_DROP_COUNT_EN to fill the drop byte with
//   an 8-bit saturating count of triggers dropped since the last accepted one.
//   Without it the drop byte is always 0x00.
//
//   Ports:
//     sampling_clk  in   sole clock, rising edge
//     reset         in   synchronous, active-high
//     trig_pulse    in   one-cycle trigger strobe
//     trig_id       in   trigger ID sampled with trig_pulse
//     ch_in         in   comparator states sampled with trig_pulse
//     ts_clear      in   zero the timestamp counter at the next edge
//     out_if        bus  byte stream (master side)
//     interrupt     out  active low while any frame is pending
//     fifo_level    out  frames held in the FIFO
//     overflow      out  sticky, set when a trigger is dropped
//     dbg_state_o   out  emitter FSM state (0 idle, 1 load, 2 send)
// -----------------------------------------------------------------------------
module event_framer #(
  parameter int CHANNELS = 24,
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 16,
  parameter int TS_WIDTH = 48
) (
  input  logic                       sampling_clk,
  input  logic                       reset,
  input  logic                       trig_pulse,
  input  logic [ID_WIDTH-1:0]        trig_id,
  input  logic [CHANNELS-1:0]        ch_in,
  input  logic                       ts_clear,
  event_framer_if.master             out_if,
  output logic                       interrupt,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [1:0]                 dbg_state_o
);

  localparam int CH_BYTES = (CHANNELS + 7) / 8;
  localparam int NB       = 3 + ID_WIDTH / 8 + TS_WIDTH / 8 + CH_BYTES;
  localparam int REC_W    = ID_WIDTH + TS_WIDTH + CH_BYTES * 8 + 8;
  localparam int FRAME_W  = NB * 8;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int LVL_W    = $clog2(DEPTH) + 1;
  localparam int IDX_W    = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [LVL_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 overflow_q;
  logic [REC_W-1:0]     mem_q [DEPTH];

  logic [CH_BYTES*8-1:0] ch_pad;
  logic [7:0]            drop_byte;
  logic [REC_W-1:0]      rec;
  logic                  push;
  logic                  pop;

  // Fullness is judged on the registered level, so a pop in the same cycle
  // never makes room for a trigger that arrives while full.
  assign push = trig_pulse && (count_q < LVL_W'(DEPTH));
  assign pop  = (state_q == S_LOAD);

  always_comb begin
    ch_pad = '0;
    ch_pad[CHANNELS-1:0] = ch_in;
  end

`ifdef OPENTRIG_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Counts drops since the last accepted trigger; the accepted record carries
  // the value seen before it and the count restarts.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      drop_cnt_d = 8'h00;
    end else if (trig_pulse && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sampling_clk) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_byte = drop_cnt_q;
`else
  assign drop_byte = 8'h00;
`endif

  // The record takes the pre-clear timestamp when ts_clear coincides.
  assign rec  = {trig_id, ts_q, ch_pad, drop_byte};
  assign ts_d = ts_clear ? '0 : ts_q + TS_WIDTH'(1);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Emitter: IDLE waits for a record, LOAD pops it into the shift register
  // wrapped in its delimiters, SEND presents the top byte and shifts on each
  // accepted byte.
  always_comb begin
    state_d          = state_q;
    shreg_d          = shreg_q;
    idx_d            = idx_q;
    out_if.out_valid = 1'b0;
    out_if.out_last  = 1'b0;
    out_if.out_data  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d = {8'h7E, mem_q[rd_ptr_q], 8'h7D};
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = shreg_q[FRAME_W-1 -: 8];
        out_if.out_last  = (idx_q == IDX_W'(NB - 1));
        if (out_if.out_ready) begin
          shreg_d = shreg_q << 8;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NB - 1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sampling_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rec;
    end
  end

  always_ff @(posedge sampling_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ts_q       <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shreg_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_q | (trig_pulse & ~push);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign fifo_level  = count_q;
  assign overflow    = overflow_q;
  assign interrupt   = !((count_q != '0) || (state_q != S_IDLE));
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_event_framer.sv
module tb_event_framer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        trig_pulse;
  logic        ts_clear;
  logic [15:0] trig_id;
  logic [23:0] ch_in;
  logic        interrupt;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [1:0]  dbg_state;

  event_framer_if bus ();

  event_framer u_dut (
    .sampling_clk (clk),
    .reset        (reset),
    .trig_pulse   (trig_pulse),
    .trig_id      (trig_id),
    .ch_in        (ch_in),
    .ts_clear     (ts_clear),
    .out_if       (bus),
    .interrupt    (interrupt),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .dbg_state_o  (dbg_state)
  );

  // Narrow configuration: 9 channels, 8-bit ID, 16-bit timestamp.
  logic       trig2;
  logic       ts_clear2;
  logic [7:0] id2;
  logic [8:0] ch2;
  logic       int2;
  logic [2:0] lvl2;
  logic       ovf2;
  logic [1:0] dbg2;

  event_framer_if bus2 ();

  event_framer #(.CHANNELS(9), .DEPTH(4), .ID_WIDTH(8), .TS_WIDTH(16)) u_dut2 (
    .sampling_clk (clk),
    .reset        (reset),
    .trig_pulse   (trig2),
    .trig_id      (id2),
    .ch_in        (ch2),
    .ts_clear     (ts_clear2),
    .out_if       (bus2),
    .interrupt    (int2),
    .fifo_level   (lvl2),
    .overflow     (ovf2),
    .dbg_state_o  (dbg2)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];   // {last, byte}
  logic [8:0] exp2_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] id, input logic [47:0] ts,
                            input logic [23:0] ch, input logic [7:0] drop);
    exp_q.push_back({1'b0, 8'h7E});
    exp_q.push_back({1'b0, id[15:8]});
    exp_q.push_back({1'b0, id[7:0]});
    for (int i = 5; i >= 0; i--) exp_q.push_back({1'b0, ts[i*8 +: 8]});
    for (int i = 2; i >= 0; i--) exp_q.push_back({1'b0, ch[i*8 +: 8]});
    exp_q.push_back({1'b0, drop});
    exp_q.push_back({1'b1, 8'h7D});
  endtask

  // Monitor for the default instance: pops on each handshake and checks that a
  // stalled byte stays put.
  initial begin : monitor
    logic       prev_stall;
    logic [8:0] prev_val;
    prev_stall = 1'b0;
    prev_val   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, prev_val});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", bus.out_data);
          end else begin
            check("frame_byte", {bus.out_last, bus.out_data}, exp_q.pop_front());
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_val   = {bus.out_last, bus.out_data};
      end
    end
  end

  initial begin : monitor2
    forever begin
      @(negedge clk);
      if (!reset && bus2.out_valid && bus2.out_ready) begin
        if (exp2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte_narrow: got %0h expected none", bus2.out_data);
        end else begin
          check("frame_byte_narrow", {bus2.out_last, bus2.out_data}, exp2_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // ready_mode: 0 hold low, 1 hold high, 2 high one cycle in three, 3 manual
  int ready_mode = 1;
  int cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0: bus.out_ready = 1'b0;
      1: bus.out_ready = 1'b1;
      2: bus.out_ready = ((cyc % 3) == 0);
      default: ;
    endcase
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves the timestamp at 0 in the current cycle.
  task automatic clear_ts();
    ts_clear = 1'b1;
    step();
    ts_clear = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(interrupt === 1'b1 && exp_q.size() == 0) && n < 400) begin
      step();
      n++;
    end
    check(name, {interrupt, (exp_q.size() == 0)}, 2'b11);
  endtask

  logic [7:0] t1 [14];
  logic [7:0] t6 [8];
  logic [7:0] drop_exp;

  // ---------------- stimulus ----------------
  initial begin
    t1 = '{8'h7E, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05,
           8'hA5, 8'hC3, 8'h01, 8'h00, 8'h7D};
    t6 = '{8'h7E, 8'h5A, 8'h00, 8'h03, 8'h01, 8'hFF, 8'h00, 8'h7D};
`ifdef OPENTRIG_DROP_COUNT_EN
    drop_exp = 8'h02;
`else
    drop_exp = 8'h00;
`endif
    reset = 1'b1;
    trig_pulse = 1'b0;
    ts_clear = 1'b0;
    trig_id = '0;
    ch_in = '0;
    bus.out_ready = 1'b1;
    trig2 = 1'b0;
    ts_clear2 = 1'b0;
    id2 = '0;
    ch2 = '0;
    bus2.out_ready = 1'b1;

    steps(3);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_last", bus.out_last, 1'b0);
    check("rst_data", bus.out_data, 8'h00);
    check("rst_interrupt", interrupt, 1'b1);
    check("rst_level", fifo_level, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b0;

    // Basic frame, timestamp 5 after reset.
    steps(5);
    trig_pulse = 1'b1;
    trig_id = 16'h1234;
    ch_in = 24'hA5C301;
    for (int i = 0; i < 14; i++) exp_q.push_back({(i == 13), t1[i]});
    step();
    trig_pulse = 1'b0;
    check("lat_level_c1", fifo_level, 3'd1);
    check("lat_int_c1", interrupt, 1'b0);
    step();
    check("lat_state_c2", dbg_state, 2'd1);
    check("lat_level_c2", fifo_level, 3'd1);
    step();
    check("lat_level_c3", fifo_level, 3'd0);
    check("lat_valid_c3", bus.out_valid, 1'b1);
    check("lat_data_c3", bus.out_data, 8'h7E);
    wait_drain("drain_basic");

    // Same frame with a stalling consumer.
    ready_mode = 2;
    clear_ts();
    steps(5);
    trig_pulse = 1'b1;
    for (int i = 0; i < 14; i++) exp_q.push_back({(i == 13), t1[i]});
    step();
    trig_pulse = 1'b0;
    wait_drain("drain_stall");

    // Seven back-to-back triggers with the consumer blocked.
    ready_mode = 0;
    steps(2);
    clear_ts();
    for (int k = 0; k < 7; k++) begin
      trig_pulse = 1'b1;
      trig_id = 16'h0100 + 16'(k);
      ch_in = 24'h000010 + 24'(k);
      if (k < 5) push_frame(trig_id, 48'(k), ch_in, 8'h00);
      step();
    end
    trig_pulse = 1'b0;
    check("full_level", fifo_level, 3'd4);
    check("full_overflow", overflow, 1'b1);
    check("full_interrupt", interrupt, 1'b0);
    check("full_head_byte", {bus.out_valid, bus.out_data}, {1'b1, 8'h7E});
    ready_mode = 1;
    wait_drain("drain_full");
    clear_ts();
    steps(2);
    trig_pulse = 1'b1;
    trig_id = 16'h0200;
    ch_in = 24'h000099;
    push_frame(16'h0200, 48'd2, 24'h000099, drop_exp);
    step();
    trig_pulse = 1'b0;
    wait_drain("drain_after_drop");
    check("overflow_sticky", overflow, 1'b1);

    // Trigger coinciding with ts_clear at timestamp 0x10.
    clear_ts();
    steps(16);
    trig_pulse = 1'b1;
    ts_clear = 1'b1;
    trig_id = 16'h0300;
    ch_in = 24'h000A0A;
    push_frame(16'h0300, 48'h10, 24'h000A0A, 8'h00);
    step();
    ts_clear = 1'b0;
    trig_id = 16'h0301;
    push_frame(16'h0301, 48'h0, 24'h000A0A, 8'h00);
    step();
    trig_pulse = 1'b0;
    wait_drain("drain_ts_clear");

    // Reset in the middle of a frame with two more queued.
    ready_mode = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      trig_pulse = 1'b1;
      trig_id = 16'h0400 + 16'(k);
      ch_in = 24'h00FF00;
      step();
    end
    trig_pulse = 1'b0;
    check("mid_level", fifo_level, 3'd2);
    check("mid_valid", bus.out_valid, 1'b1);
    ready_mode = 3;
    bus.out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h7E});
    exp_q.push_back({1'b0, 8'h04});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h00});
    steps(4);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    step();
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_level", fifo_level, 3'd0);
    check("mid_rst_interrupt", interrupt, 1'b1);
    check("mid_rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    ready_mode = 1;
    steps(40);
    check("mid_no_more_bytes", exp_q.size(), 0);

    // Narrow instance: 9 channels, ID 0x5A, timestamp 3.
    ts_clear2 = 1'b1;
    step();
    ts_clear2 = 1'b0;
    steps(3);
    trig2 = 1'b1;
    id2 = 8'h5A;
    ch2 = 9'h1FF;
    for (int i = 0; i < 8; i++) exp2_q.push_back({(i == 7), t6[i]});
    step();
    trig2 = 1'b0;
    begin
      int n;
      n = 0;
      while (!(int2 === 1'b1 && exp2_q.size() == 0) && n < 100) begin
        step();
        n++;
      end
    end
    check("narrow_done", {int2, (exp2_q.size() == 0)}, 2'b11);

    check("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
